irq_timer_gen: RTL and testbench

IRQ_TIMER_GEN -- requirements
Module: irq_timer_gen

---
 rtl/irq_timer_gen.sv | 131 +++++++++++++
 tb/tb_irq_timer_gen.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/irq_timer_gen.sv
// Periodic interrupt generator: N_CH independent channels, each a reloading down-counter
// that fires in pulse mode (fixed high time) or level mode (held until ack, overrun on a missed ack).
// irq and overrun come straight from flops; a config write always wins over ack and fire on the same edge.
module irq_timer_gen #(
    parameter int N_CH    = 8,
    parameter int CNT_W   = 32,
    parameter int PULSE_W = 4
) (
    input  logic                    axi_aclk,
    input  logic                    axi_aresetn,
    input  logic                    cfg_wr,
    input  logic [$clog2(N_CH)-1:0] cfg_ch,
    input  logic [CNT_W-1:0]        cfg_period,
    input  logic                    cfg_en,
    input  logic                    cfg_level,
    input  logic [N_CH-1:0]         ack,
    output logic [N_CH-1:0]         irq,
    output logic [N_CH-1:0]         overrun
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        ASSERT = 2'd2
    } state_t;

    localparam int              PW_W    = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
    localparam logic [CNT_W-1:0] MIN_P  = CNT_W'(PULSE_W + 1);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam logic [PW_W-1:0]  PW_LAST = PW_W'(PULSE_W - 1);

    logic [31:0]      ch_sel;
    logic [CNT_W-1:0] eff_period;

    // An out-of-range channel number matches no channel below and is dropped.
    assign ch_sel     = 32'(cfg_ch);
    assign eff_period = (cfg_period < MIN_P) ? MIN_P : cfg_period;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        state_t           state_q, state_d;
        logic [CNT_W-1:0] period_q, period_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             en_q, en_d;
        logic             level_q, level_d;
        logic             irq_q, irq_d;
        logic             ovr_q, ovr_d;
        logic [PW_W-1:0]  pcnt_q, pcnt_d;
        logic             wr_hit;
        logic             fire;

        assign wr_hit = cfg_wr && (ch_sel == 32'(c));
        assign fire   = en_q && (state_q != IDLE) && (cnt_q == '0);

        always_comb begin
            state_d  = state_q;
            period_d = period_q;
            cnt_d    = cnt_q;
            en_d     = en_q;
            level_d  = level_q;
            irq_d    = irq_q;
            ovr_d    = ovr_q;
            pcnt_d   = pcnt_q;
            if (wr_hit) begin
                period_d = eff_period;
                en_d     = cfg_en;
                level_d  = cfg_level;
                irq_d    = 1'b0;
                ovr_d    = 1'b0;
                pcnt_d   = '0;
                if (cfg_en) begin
                    cnt_d   = eff_period - ONE;
                    state_d = COUNT;
                end else begin
                    state_d = IDLE;
                end
            end else begin
                unique case (state_q)
                    COUNT: begin
                        cnt_d = fire ? (period_q - ONE) : (cnt_q - ONE);
                        if (irq_q) begin
                            if (pcnt_q != '0) pcnt_d = pcnt_q - PW_W'(1);
                            else              irq_d  = 1'b0;
                        end
                        if (fire) begin
                            irq_d = 1'b1;
                            if (level_q) state_d = ASSERT;
                            else         pcnt_d  = PW_LAST;
                        end
                    end
                    ASSERT: begin
                        cnt_d = fire ? (period_q - ONE) : (cnt_q - ONE);
                        // An ack landing on a fire edge re-arms the new event instead of flagging it.
                        if (fire) begin
                            if (!ack[c]) ovr_d = 1'b1;
                        end else if (ack[c]) begin
                            irq_d   = 1'b0;
                            state_d = COUNT;
                        end
                    end
                    default: ;
                endcase
            end
        end

        always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
            if (!axi_aresetn) begin
                state_q  <= IDLE;
                period_q <= MIN_P;
                cnt_q    <= '0;
                en_q     <= 1'b0;
                level_q  <= 1'b0;
                irq_q    <= 1'b0;
                ovr_q    <= 1'b0;
                pcnt_q   <= '0;
            end else begin
                state_q  <= state_d;
                period_q <= period_d;
                cnt_q    <= cnt_d;
                en_q     <= en_d;
                level_q  <= level_d;
                irq_q    <= irq_d;
                ovr_q    <= ovr_d;
                pcnt_q   <= pcnt_d;
            end
        end

        assign irq[c]     = irq_q;
        assign overrun[c] = ovr_q;
    end

endmodule

// File: tb/tb_irq_timer_gen.sv
// Directed bench for irq_timer_gen: hand-computed irq/overrun timelines per scenario,
// plus a 6-channel instance whose 3-bit channel field can address non-existent channels.
module tb_irq_timer_gen;

    logic        axi_aclk;
    logic        axi_aresetn;
    logic        cfg_wr;
    logic [2:0]  cfg_ch;
    logic [31:0] cfg_period;
    logic        cfg_en;
    logic        cfg_level;
    logic [7:0]  ack;
    logic [7:0]  irq;
    logic [7:0]  overrun;
    logic [5:0]  irq6;
    logic [5:0]  ovr6;

    int tests = 0;
    int fails = 0;

    irq_timer_gen #(.N_CH(8), .CNT_W(32), .PULSE_W(4)) dut (
        .axi_aclk    (axi_aclk),
        .axi_aresetn (axi_aresetn),
        .cfg_wr      (cfg_wr),
        .cfg_ch      (cfg_ch),
        .cfg_period  (cfg_period),
        .cfg_en      (cfg_en),
        .cfg_level   (cfg_level),
        .ack         (ack),
        .irq         (irq),
        .overrun     (overrun)
    );

    irq_timer_gen #(.N_CH(6), .CNT_W(8), .PULSE_W(4)) dut6 (
        .axi_aclk    (axi_aclk),
        .axi_aresetn (axi_aresetn),
        .cfg_wr      (cfg_wr),
        .cfg_ch      (cfg_ch),
        .cfg_period  (cfg_period[7:0]),
        .cfg_en      (cfg_en),
        .cfg_level   (cfg_level),
        .ack         (ack[5:0]),
        .irq         (irq6),
        .overrun     (ovr6)
    );

    initial axi_aclk = 1'b0;
    always #5 axi_aclk = ~axi_aclk;

    task automatic tick(input int n);
        repeat (n) @(posedge axi_aclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int ch, input int per, input logic en, input logic lvl);
        cfg_wr     = 1'b1;
        cfg_ch     = 3'(ch);
        cfg_period = 32'(per);
        cfg_en     = en;
        cfg_level  = lvl;
        tick(1);
        cfg_wr     = 1'b0;
    endtask

    initial begin
        logic [7:0] any_irq;
        axi_aresetn = 1'b0;
        cfg_wr      = 1'b0;
        cfg_ch      = '0;
        cfg_period  = '0;
        cfg_en      = 1'b0;
        cfg_level   = 1'b0;
        ack         = '0;
        #23;
        check("rst_irq", irq, 8'h00);
        check("rst_ovr", overrun, 8'h00);
        axi_aresetn = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            check("post_rst_quiet", irq, 8'h00);
        end

        // ch0 pulse mode, period 10
        wr(0, 10, 1'b1, 1'b0);
        for (int k = 1; k <= 25; k++) begin
            tick(1);
            check("pulse_ch0", irq, ((k >= 10 && k <= 13) || (k >= 20 && k <= 23)) ? 8'h01 : 8'h00);
        end
        wr(0, 10, 1'b0, 1'b0);
        check("ch0_off", irq, 8'h00);

        // ch3 level mode, period 8, overrun then late ack
        wr(3, 8, 1'b1, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            check("lvl_ch3_irq", irq, (k >= 8) ? 8'h08 : 8'h00);
            check("lvl_ch3_ovr", overrun, (k >= 16) ? 8'h08 : 8'h00);
        end
        ack = 8'h08;
        tick(1);
        ack = 8'h00;
        check("ack_ch3_irq", irq, 8'h00);
        check("ack_ch3_ovr_sticky", overrun, 8'h08);
        tick(2);
        check("ch3_idle_gap", irq, 8'h00);
        tick(1);
        check("ch3_refire", irq, 8'h08);
        wr(3, 8, 1'b0, 1'b0);
        check("ch3_off_irq", irq, 8'h00);
        check("ch3_off_ovr", overrun, 8'h00);

        // ch1 level, period 6: ack exactly on the second fire edge
        wr(1, 6, 1'b1, 1'b1);
        for (int k = 1; k <= 11; k++) begin
            tick(1);
            check("lvl_ch1_irq", irq, (k >= 6) ? 8'h02 : 8'h00);
            check("lvl_ch1_ovr", overrun, 8'h00);
        end
        ack = 8'h02;
        tick(1);
        ack = 8'h00;
        check("ack_fire_irq", irq, 8'h02);
        check("ack_fire_ovr", overrun, 8'h00);
        for (int k = 13; k <= 18; k++) begin
            tick(1);
            check("ch1_hold_irq", irq, 8'h02);
            check("ch1_hold_ovr", overrun, (k >= 18) ? 8'h02 : 8'h00);
        end
        ack = 8'h02;
        tick(1);
        ack = 8'h00;
        check("ch1_ack_drop", irq, 8'h00);
        wr(1, 6, 1'b0, 1'b0);

        // ch2 period 1 clamps to 5; disable mid-pulse
        wr(2, 1, 1'b1, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            tick(1);
            check("clamp_ch2", irq,
                  ((k >= 5 && k <= 8) || (k >= 10 && k <= 13) || k >= 15) ? 8'h04 : 8'h00);
        end
        wr(2, 1, 1'b0, 1'b0);
        check("midpulse_off", irq, 8'h00);
        for (int k = 0; k < 10; k++) begin
            tick(1);
            check("ch2_stays_off", irq, 8'h00);
        end

        // ch4 level: rewrite lands on a fire edge while unacknowledged, ack also high
        wr(4, 6, 1'b1, 1'b1);
        for (int k = 1; k <= 11; k++) begin
            tick(1);
            check("ch4_irq", irq, (k >= 6) ? 8'h10 : 8'h00);
        end
        ack = 8'h10;
        wr(4, 6, 1'b1, 1'b1);
        ack = 8'h00;
        check("cfg_wins_irq", irq, 8'h00);
        check("cfg_wins_ovr", overrun, 8'h00);
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            check("ch4_rearm", irq, (k == 6) ? 8'h10 : 8'h00);
        end
        wr(4, 6, 1'b0, 1'b0);

        // all channels, then asynchronous reset mid-run
        for (int c = 0; c < 8; c++) wr(c, 3 + c, 1'b1, c[0]);
        any_irq = 8'h00;
        for (int k = 0; k < 30; k++) begin
            tick(1);
            any_irq |= irq;
        end
        check("all_ch_fired", any_irq, 8'hFF);
        check("lvl_overruns", overrun, 8'hAA);
        #3;
        axi_aresetn = 1'b0;
        #1;
        check("async_rst_irq", irq, 8'h00);
        check("async_rst_ovr", overrun, 8'h00);
        tick(2);
        axi_aresetn = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick(1);
            check("after_rst_irq", irq, 8'h00);
            check("after_rst_ovr", overrun, 8'h00);
        end
        wr(5, 7, 1'b1, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            tick(1);
            check("ch5_after_rst", irq, (k == 7) ? 8'h20 : 8'h00);
        end
        wr(5, 7, 1'b0, 1'b0);

        // acks on idle channels do nothing
        for (int k = 0; k < 100; k++) begin
            ack = (k % 2 == 0) ? 8'hFF : 8'h00;
            tick(1);
            check("idle_ack_irq", irq, 8'h00);
            check("idle_ack_ovr", overrun, 8'h00);
        end
        ack = 8'h00;

        // out-of-range channel writes on the 6-channel instance
        wr(6, 5, 1'b1, 1'b1);
        wr(7, 5, 1'b1, 1'b0);
        for (int k = 0; k < 100; k++) begin
            tick(1);
            check("oor_irq6", {2'b00, irq6}, 8'h00);
            check("oor_ovr6", {2'b00, ovr6}, 8'h00);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
